alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter W, default 32, operand/result width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  async active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command FIFO not full.
REQ-008 SHALL have port cmd_op  input  3  {M,S1,S0} ALU opcode.
REQ-009 SHALL have port cmd_chain  input  1  replace A with accumulator.
REQ-010 SHALL have port cmd_a  input  W  operand A.
REQ-011 SHALL have port cmd_b  input  W  operand B.
REQ-012 SHALL have port rsp_valid  output  1  result available.
REQ-013 SHALL have port rsp_ready  input  1  result consumed.
REQ-014 SHALL have port rsp_result  output  W  ALU result.
REQ-015 SHALL have port rsp_ovf  output  1  add/sub signed overflow for this result.
REQ-016 SHALL have port rsp_zero  output  1  result == 0.
REQ-017 SHALL have port busy  output  1  FSM not IDLE or FIFO non-empty.
REQ-018 SHALL have port ovf_sticky  output  1  any overflow since last clear.
REQ-019 SHALL have port clr_sticky  input  1  synchronous clear of ovf_sticky (and trap).

Function
REQ-020 SHALL decode opcodes: 000 NOT A, 001 A&B, 010 A^B, 011 A|B, 100 A-1, 101 A+B, 110 A-B, 111 A+1.
REQ-021 SHALL push a command on any edge where cmd_valid && cmd_ready; cmd_ready = !full, independent of cmd_valid.
REQ-022 SHALL implement FSM IDLE -> EXEC -> RESP: IDLE pops head when FIFO non-empty; EXEC captures ALU outputs into response registers, sets rsp_valid; RESP holds until rsp_ready, then pops next (-> EXEC) or -> IDLE.
REQ-023 SHALL deliver first rsp_valid two edges after the accepting edge when idle and empty; sustained throughput one result per two cycles.
REQ-024 SHALL keep rsp_result/rsp_ovf/rsp_zero stable while rsp_valid && !rsp_ready.
REQ-025 SHALL use accumulator (last captured result) as A when cmd_chain=1; accumulator updates on every EXEC capture.
REQ-026 SHALL force rsp_ovf=0 for non-add/sub opcodes; overflow = signed overflow of A+B or A-B.
REQ-027 SHALL set ovf_sticky on EXEC capture with overflow; clr_sticky same cycle as a new overflow leaves ovf_sticky=1.
REQ-028 SHALL wrap FIFO pointers modulo DEPTH; simultaneous push and pop when non-full keeps count constant.

Reset
REQ-029 SHALL on rst_n=0, at any time: flush FIFO, state=IDLE, rsp_valid=0, rsp_result=0, rsp_ovf=0, rsp_zero=0, accumulator=0, ovf_sticky=0; cmd_ready=1 and busy=0 after reset.

Configuration
REQ-030 SHALL, with ALU_SEQ_OVF_TRAP_EN defined, add state TRAP: an overflow capture goes RESP -> TRAP after rsp_ready; TRAP pops nothing (FIFO still accepts) until clr_sticky, then -> IDLE.
REQ-031 SHALL, without ALU_SEQ_OVF_TRAP_EN, omit TRAP; overflow only sets ovf_sticky, sequencing continues.

Structure
REQ-032 SHALL place opcode localparams, FSM state encoding and default DEPTH in package alu_seq_pkg.
REQ-033 SHALL implement the command queue as sub-module alu_seq_fifo; ALU datapath is the existing 32-bit ALU instantiated combinationally on the operand registers.

Verification
REQ-034 SHALL cover: op 101, A=10, B=20 -> rsp_result=30, rsp_ovf=0, rsp_zero=0, two edges after accept.
REQ-035 SHALL cover: op 110, A=30, B=30 -> rsp_result=0, rsp_zero=1; then op 101, A=0x7FFFFFFF, B=1 -> 0x80000000, rsp_ovf=1, ovf_sticky=1.
REQ-036 SHALL cover: op 101 A=5 B=3, then op 111 cmd_chain=1 -> results 8 then 9.
REQ-037 SHALL cover: rsp_ready=0, push 5 commands -> one in EXEC/RESP, 4 in FIFO, cmd_ready=0; result held stable; release -> all in order.
REQ-038 SHALL cover: rst_n low while RESP with 3 queued -> rsp_valid=0, busy=0, cmd_ready=1, no stale results after release.
REQ-039 SHALL cover (ALU_SEQ_OVF_TRAP_EN): overflow then queued op 001 -> no further rsp_valid until clr_sticky, then op 001 result delivered.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared opcodes, FSM state encoding and default queue depth for
//             the ALU command sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam int ALU_SEQ_DEPTH = 4;

    // Opcode bits are {M,S1,S0}: M=0 selects logic ops, M=1 selects arithmetic
    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2,
        ST_TRAP = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_fifo.sv
// ============================================================================
//  Module   : alu_seq_fifo
//  Purpose  : Power-of-two command queue with free-running wrapping pointers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage is not reset; flushing the pointers is enough to discard it
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ============================================================================
//  Module   : alu_seq_ctrl
//  Purpose  : Queued ALU sequencer: FIFO -> operand regs -> ALU -> response.
//             Optional overflow trap state enabled by ALU_SEQ_OVF_TRAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = ALU_SEQ_DEPTH,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_chain,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_ovf,
    output logic         rsp_zero,
    output logic         busy,
    output logic         ovf_sticky,
    input  logic         clr_sticky
);

    localparam int CMD_W = 4 + 2 * W;
    localparam logic [W-1:0] ONE_W = W'(1);

    state_t       state;
    state_t       state_nxt;
    logic         pop;
    logic         capture;
    logic         full;
    logic         empty;
    logic [CMD_W-1:0] head;
    logic [2:0]   op_reg;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] acc;
    logic [W-1:0] alu_res;
    logic         alu_ovf;

    assign cmd_ready = !full;
    assign busy      = (state != ST_IDLE) || !empty;

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && !full),
        .push_data ({cmd_op, cmd_chain, cmd_a, cmd_b}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_reg)
            OP_NOT: alu_res = ~a_reg;
            OP_AND: alu_res = a_reg & b_reg;
            OP_XOR: alu_res = a_reg ^ b_reg;
            OP_OR:  alu_res = a_reg | b_reg;
            OP_DEC: alu_res = a_reg - ONE_W;
            OP_ADD: begin
                alu_res = a_reg + b_reg;
                alu_ovf = (a_reg[W-1] == b_reg[W-1]) && (alu_res[W-1] != a_reg[W-1]);
            end
            OP_SUB: begin
                alu_res = a_reg - b_reg;
                alu_ovf = (a_reg[W-1] != b_reg[W-1]) && (alu_res[W-1] != a_reg[W-1]);
            end
            default: alu_res = a_reg + ONE_W;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture   = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
`ifdef ALU_SEQ_OVF_TRAP_EN
                    if (rsp_ovf) begin
                        state_nxt = ST_TRAP;
                    end else
`endif
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = ST_EXEC;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
`ifdef ALU_SEQ_OVF_TRAP_EN
            ST_TRAP: begin
                if (clr_sticky) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc        <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
            rsp_zero   <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            // Chained A is resolved at pop time; the previous capture is already in acc
            if (pop) begin
                op_reg <= head[CMD_W-1 -: 3];
                a_reg  <= head[2*W] ? acc : head[2*W-1 -: W];
                b_reg  <= head[W-1:0];
            end
            if (capture) begin
                acc        <= alu_res;
                rsp_result <= alu_res;
                rsp_ovf    <= alu_ovf;
                rsp_zero   <= (alu_res == '0);
                rsp_valid  <= 1'b1;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
            // A new overflow wins over a simultaneous clear
            if (capture && alu_ovf) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
//  Module   : tb_alu_seq_ctrl
//  Purpose  : Directed, table-driven self-checking bench for alu_seq_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic        cmd_chain;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_ovf;
    logic        rsp_zero;
    logic        busy;
    logic        ovf_sticky;
    logic        clr_sticky;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic        chain;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DEPTH(4), .W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_chain  (cmd_chain),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_ovf    (rsp_ovf),
        .rsp_zero   (rsp_zero),
        .busy       (busy),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic push_cmd(input logic [2:0] op, input logic ch,
                            input logic [31:0] a, input logic [31:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_chain = ch;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Push into an idle, empty design and check the two-edge response latency
    task automatic run_one(input logic [2:0] op, input logic ch,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic ovf, input logic zero,
                           input string name);
        push_cmd(op, ch, a, b);
        @(posedge clk); #1;
        chk({name, "_early_valid"}, {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk({name, "_valid"},  {31'd0, rsp_valid}, 32'd1);
        chk({name, "_result"}, rsp_result, res);
        chk({name, "_ovf"},    {31'd0, rsp_ovf},  {31'd0, ovf});
        chk({name, "_zero"},   {31'd0, rsp_zero}, {31'd0, zero});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic got;
        logic hold_ok;

        vecs[0]  = '{3'b101, 1'b0, 32'd10,        32'd20,        32'd30,        1'b0, 1'b0};
        vecs[1]  = '{3'b110, 1'b0, 32'd30,        32'd30,        32'd0,         1'b0, 1'b1};
        vecs[2]  = '{3'b000, 1'b0, 32'h0F0F0F0F,  32'h0,         32'hF0F0F0F0,  1'b0, 1'b0};
        vecs[3]  = '{3'b001, 1'b0, 32'hFF00FF00,  32'h0F0F0F0F,  32'h0F000F00,  1'b0, 1'b0};
        vecs[4]  = '{3'b010, 1'b0, 32'hFFFF0000,  32'h0F0F0F0F,  32'hF0F00F0F,  1'b0, 1'b0};
        vecs[5]  = '{3'b011, 1'b0, 32'h12340000,  32'h00005678,  32'h12345678,  1'b0, 1'b0};
        vecs[6]  = '{3'b100, 1'b0, 32'h0,         32'h0,         32'hFFFFFFFF,  1'b0, 1'b0};
        vecs[7]  = '{3'b111, 1'b0, 32'hFFFFFFFF,  32'h0,         32'h0,         1'b0, 1'b1};
        vecs[8]  = '{3'b101, 1'b0, 32'd5,         32'd3,         32'd8,         1'b0, 1'b0};
        vecs[9]  = '{3'b111, 1'b1, 32'd100,       32'd0,         32'd9,         1'b0, 1'b0};
        vecs[10] = '{3'b110, 1'b0, 32'd5,         32'd7,         32'hFFFFFFFE,  1'b0, 1'b0};
        vecs[11] = '{3'b101, 1'b1, 32'd0,         32'd2,         32'h0,         1'b0, 1'b1};
        vecs[12] = '{3'b111, 1'b0, 32'h7FFFFFFF,  32'd0,         32'h80000000,  1'b0, 1'b0};
        vecs[13] = '{3'b100, 1'b0, 32'h80000000,  32'd0,         32'h7FFFFFFF,  1'b0, 1'b0};

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'b000;
        cmd_chain  = 1'b0;
        cmd_a      = '0;
        cmd_b      = '0;
        rsp_ready  = 1'b1;
        clr_sticky = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        chk("rst_cmd_ready",  {31'd0, cmd_ready},  32'd1);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_ovf_sticky", {31'd0, ovf_sticky}, 32'd0);
        chk("rst_result",     rsp_result,          32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_one(vecs[i].op, vecs[i].chain, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].ovf, vecs[i].zero, $sformatf("vec%0d", i));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_consumed", i), {31'd0, rsp_valid}, 32'd0);
        end
        chk("table_no_sticky", {31'd0, ovf_sticky}, 32'd0);

        // Signed add overflow sets the flag and the sticky bit
        run_one(3'b101, 1'b0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0, "ovf_add");
        chk("ovf_sticky_set", {31'd0, ovf_sticky}, 32'd1);
`ifdef ALU_SEQ_OVF_TRAP_EN
        @(posedge clk); #1;
        push_cmd(3'b001, 1'b0, 32'hF0, 32'h3C);
        hold_ok = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            if (rsp_valid) hold_ok = 1'b0;
        end
        chk("trap_no_rsp",    {31'd0, hold_ok},   32'd1);
        chk("trap_busy",      {31'd0, busy},      32'd1);
        chk("trap_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        chk("trap_sticky_clr", {31'd0, ovf_sticky}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("trap_rel_valid",  {31'd0, rsp_valid}, 32'd1);
        chk("trap_rel_result", rsp_result,         32'h30);
        @(posedge clk); #1;
`else
        @(posedge clk); #1;
        run_one(3'b001, 1'b0, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, "after_ovf");
        chk("sticky_holds", {31'd0, ovf_sticky}, 32'd1);
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        chk("sticky_cleared", {31'd0, ovf_sticky}, 32'd0);
        // Clear held across a new overflow capture: set must win
        clr_sticky = 1'b1;
        run_one(3'b110, 1'b0, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0, "ovf_sub");
        chk("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
        clr_sticky = 1'b0;
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
`endif

        // Backpressure: five commands fill EXEC/RESP plus the four-entry queue
        rsp_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push_cmd(3'b101, 1'b0, 32'(k), 32'd100);
        end
        chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("bp_valid",     {31'd0, rsp_valid}, 32'd1);
        chk("bp_busy",      {31'd0, busy},      32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 3'b101;
        cmd_a     = 32'd99;
        cmd_b     = 32'd100;
        hold_ok   = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_result !== 32'd101 || rsp_ovf !== 1'b0 || rsp_zero !== 1'b0)
                hold_ok = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("bp_hold_stable", {31'd0, hold_ok}, 32'd1);
        rsp_ready = 1'b1;
        chk("bp_order1", rsp_result, 32'd101);
        for (int k = 2; k <= 5; k++) begin
            got = 1'b0;
            for (int t = 0; t < 6; t++) begin
                @(posedge clk); #1;
                if (rsp_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("bp_got%0d", k),   {31'd0, got}, 32'd1);
            chk($sformatf("bp_order%0d", k), rsp_result,   32'(k + 100));
        end
        hold_ok = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            if (rsp_valid) hold_ok = 1'b0;
        end
        chk("bp_no_extra", {31'd0, hold_ok}, 32'd1);
        chk("bp_idle",     {31'd0, busy},    32'd0);

        // Asynchronous reset while holding a response with three queued
        rsp_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push_cmd(3'b101, 1'b0, 32'(k), 32'd200);
        end
        @(posedge clk); #1;
        chk("rr_pre_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_valid",     {31'd0, rsp_valid}, 32'd0);
        chk("rr_busy",      {31'd0, busy},      32'd0);
        chk("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rr_result",    rsp_result,         32'd0);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        hold_ok = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            if (rsp_valid) hold_ok = 1'b0;
        end
        chk("rr_no_stale", {31'd0, hold_ok}, 32'd1);
        run_one(3'b111, 1'b1, 32'd55, 32'd0, 32'd1, 1'b0, 1'b0, "rr_acc_cleared");
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
